spi_flash_arbiter: RTL

Shares the single off-chip SPI flash ROM between two read requesters: port 0 (video line prefetch) and port 1 (auxiliary/config fetch). The block sequences a complete SPI read transaction (command, 24-bit address, data bytes) for each granted request and streams the returned bytes back, tagged with the requester ID. It sits between the VGA pixel pipeline and the flash pins, owning /CS, SCLK and the io0 output enable.

---
 rtl/spi_flash_pkg.sv | 25 ++
 rtl/spi_flash_shifter.sv | 82 ++++++++
 rtl/spi_flash_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, phase lengths and FSM state encoding for the SPI flash read arbiter.
package spi_flash_pkg;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;
    localparam int DATA_BITS  = 8;

    // Shift word is left-aligned; the widest phase (address) sets its width.
    localparam int SHIFT_W  = 24;
    localparam int BITCNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_flash_shifter.sv
// Two-cycle-per-bit SPI mode-0 engine: phase L drives MOSI with SCLK low, phase H raises SCLK,
// MISO is captured on the clk edge that ends phase H.
module spi_flash_shifter
    import spi_flash_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SHIFT_W-1:0]  load_word,
    input  logic [BITCNT_W-1:0] load_bits,
    input  logic                spi_miso,
    output logic                spi_sclk,
    output logic                spi_mosi,
    output logic                bit_done,
    output logic                last_bit,
    output logic [7:0]          rx_next
);

    logic                active_q, active_d;
    logic                phase_q, phase_d;
    logic                sclk_q, sclk_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [BITCNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]          rx_q, rx_d;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        sclk_d   = sclk_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;

        bit_done = active_q & phase_q;
        last_bit = (cnt_q == '0);
        rx_next  = {rx_q[6:0], spi_miso};

        // A load may land on the final phase H so consecutive words stream without a gap.
        if (load) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            sclk_d   = 1'b0;
            shift_d  = load_word;
            cnt_d    = load_bits - BITCNT_W'(1);
        end else if (active_q) begin
            phase_d = ~phase_q;
            sclk_d  = ~phase_q;
            if (phase_q) begin
                if (cnt_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - BITCNT_W'(1);
                end
            end
        end

        if (bit_done) begin
            rx_d = rx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            sclk_q   <= 1'b0;
            shift_q  <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
        end
        cnt_q <= cnt_d;
        rx_q  <= rx_d;
    end

    assign spi_sclk = sclk_q;
    assign spi_mosi = shift_q[SHIFT_W-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash between two read requesters.
// Define SPI_FLASH_ARB_FAST_READ_EN to issue 0x0B with an 8-bit dummy phase instead of 0x03.
module spi_flash_arbiter
    import spi_flash_pkg::*;
#(
    parameter int LEN_W   = 6,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [23:0]      req0_addr,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [23:0]      req1_addr,
    input  logic [LEN_W-1:0] req1_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_id,
    output logic             rd_last,
    output logic             busy,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    output logic             spi_mosi_oe,
    input  logic             spi_miso
);

`ifdef SPI_FLASH_ARB_FAST_READ_EN
    localparam logic [7:0] CMD_OP    = SPI_CMD_FAST_READ;
    localparam bit         USE_DUMMY = 1'b1;
`else
    localparam logic [7:0] CMD_OP    = SPI_CMD_READ;
    localparam bit         USE_DUMMY = 1'b0;
`endif

    // The cycle spent in IDLE counts toward the /CS-high gap, so GAP holds GAP_CYC-1 cycles.
    localparam int               GAP_W    = 8;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

    spi_state_e          state_q, state_d;
    logic                rr_q, rr_d;
    logic                id_q, id_d;
    logic [23:0]         addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                cs_n_q, cs_n_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                rd_id_q, rd_id_d;
    logic [7:0]          rd_data_q, rd_data_d;

    logic                grant0, grant1, word_end;
    logic                sh_load, sh_bit_done, sh_last_bit;
    logic [SHIFT_W-1:0]  sh_word;
    logic [BITCNT_W-1:0] sh_bits;
    logic [7:0]          sh_rx;

    spi_flash_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_word (sh_word),
        .load_bits (sh_bits),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .bit_done  (sh_bit_done),
        .last_bit  (sh_last_bit),
        .rx_next   (sh_rx)
    );

    always_comb begin
        grant0     = req0_valid & (~rr_q | ~req1_valid);
        grant1     = req1_valid & (rr_q | ~req0_valid);
        req0_ready = (state_q == ST_IDLE) & grant0;
        req1_ready = (state_q == ST_IDLE) & grant1;
        word_end   = sh_bit_done & sh_last_bit;

        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cs_n_d     = cs_n_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_id_d    = rd_id_q;
        rd_data_d  = rd_data_q;
        sh_load    = 1'b0;
        sh_word    = '0;
        sh_bits    = BITCNT_W'(DATA_BITS);

        case (state_q)
            ST_IDLE: begin
                if (req0_ready | req1_ready) begin
                    id_d       = req1_ready;
                    addr_d     = req1_ready ? req1_addr : req0_addr;
                    len_d      = req1_ready ? req1_len : req0_len;
                    rr_d       = ~req1_ready;
                    byte_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_CMD;
                    sh_load    = 1'b1;
                    sh_word    = {CMD_OP, 16'h0000};
                    sh_bits    = BITCNT_W'(CMD_BITS);
                end
            end
            ST_CMD: begin
                if (word_end) begin
                    state_d = ST_ADDR;
                    sh_load = 1'b1;
                    sh_word = addr_q;
                    sh_bits = BITCNT_W'(ADDR_BITS);
                end
            end
            ST_ADDR: begin
                if (word_end) begin
                    oe_d    = 1'b0;
                    sh_load = 1'b1;
                    sh_bits = BITCNT_W'(USE_DUMMY ? DUMMY_BITS : DATA_BITS);
                    state_d = USE_DUMMY ? ST_DUMMY : ST_DATA;
                end
            end
            ST_DUMMY: begin
                if (word_end) begin
                    state_d = ST_DATA;
                    sh_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (word_end) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = sh_rx;
                    rd_id_d    = id_q;
                    rd_last_d  = (byte_cnt_q == len_q);
                    if (byte_cnt_q == len_q) begin
                        cs_n_d = 1'b1;
                        if (GAP_CYC > 1) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            oe_d    = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + LEN_W'(1);
                        sh_load    = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    oe_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_q       <= 1'b1;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cs_n_q     <= cs_n_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_id_q    <= rd_id_d;
            rd_data_q  <= rd_data_d;
        end
        id_q       <= id_d;
        addr_q     <= addr_d;
        len_q      <= len_d;
        byte_cnt_q <= byte_cnt_d;
        gap_cnt_q  <= gap_cnt_d;
    end

    assign spi_cs_n    = cs_n_q;
    assign spi_mosi_oe = oe_q;
    assign busy        = busy_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_id       = rd_id_q;
    assign rd_data     = rd_data_q;

endmodule
